// File: rtl/taktteiler_pkg.sv
// Shared types and constants for the Taktteiler clock-divider controller.
package taktteiler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 10;
    localparam int unsigned MIN_DIV   = 1;

endpackage

// File: rtl/taktteiler_core.sv
// Period counter with clear/enable and wrap compare against the active divisor.
module taktteiler_core
    import taktteiler_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] count_next_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign wrap_o       = (count_q == (div_i - WIDTH'(1)));
    assign count_o      = count_q;
    assign count_next_o = count_d;

    // Next count: clear wins, otherwise step and fold back to 0 on the last cycle of a period.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = wrap_o ? '0 : (count_q + WIDTH'(1));
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/taktteiler_ctrl.sv
// Taktteiler controller: run/stop sequencing, divisor handshake with
// period-boundary update, tick and divided-clock generation.
// Optional TAKT_ONESHOT_EN adds a 'oneshot' input that runs a single period.
module taktteiler_ctrl
    import taktteiler_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned DEFAULT_DIV = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             busy,
    output logic             tick,
    output logic             div_out,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] div_active
`ifdef TAKT_ONESHOT_EN
    ,
    input  logic             oneshot
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] div_active_q, div_active_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_valid_q, pend_valid_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             div_out_q, div_out_d;
    logic             tick_q, tick_d;
    logic             busy_q;

    logic [WIDTH-1:0] count_cur, count_next;
    logic             core_wrap;
    logic             running, wrap_evt, xfer, oneshot_sel, core_clear;
    logic [WIDTH-1:0] cfg_div_c;

    assign running   = (state_q != ST_IDLE);
    assign wrap_evt  = running && core_wrap;
    assign xfer      = cfg_valid && cfg_ready_q;
    assign cfg_div_c = (cfg_div == '0) ? WIDTH'(MIN_DIV) : cfg_div;

`ifdef TAKT_ONESHOT_EN
    assign oneshot_sel = oneshot;
`else
    assign oneshot_sel = 1'b0;
`endif

    // Next-state decode for the FSM, divisor bookkeeping and divided clock.
    always_comb begin
        state_d      = state_q;
        div_active_d = div_active_q;
        pend_div_d   = pend_div_q;
        pend_valid_d = pend_valid_q;
        cfg_ready_d  = cfg_ready_q;
        div_out_d    = div_out_q;

        unique case (state_q)
            ST_IDLE:     if (start && !stop) state_d = oneshot_sel ? ST_STOPPING : ST_RUN;
            ST_RUN:      if (stop) state_d = ST_STOPPING;
            ST_STOPPING: if (wrap_evt) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (!running) begin
            if (xfer) div_active_d = cfg_div_c;
        end else begin
            if (wrap_evt) begin
                div_out_d = ~div_out_q;
                if (pend_valid_q) begin
                    div_active_d = pend_div_q;
                    pend_valid_d = 1'b0;
                    cfg_ready_d  = 1'b1;
                end
            end
            // A divisor accepted on the final wrap of a stop goes straight in,
            // since IDLE never wraps to apply a pending value.
            if (xfer) begin
                if (wrap_evt && (state_d == ST_IDLE)) begin
                    div_active_d = cfg_div_c;
                end else begin
                    pend_div_d   = cfg_div_c;
                    pend_valid_d = 1'b1;
                    cfg_ready_d  = 1'b0;
                end
            end
        end
    end

    assign core_clear = (state_d == ST_IDLE);
    // Tick is registered from the look-ahead count so it lines up with the last count value.
    assign tick_d     = (state_d != ST_IDLE) && (count_next == (div_active_d - WIDTH'(1)));

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_active_q <= WIDTH'(DEFAULT_DIV);
            pend_div_q   <= '0;
            pend_valid_q <= 1'b0;
            cfg_ready_q  <= 1'b1;
            div_out_q    <= 1'b0;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_active_q <= div_active_d;
            pend_div_q   <= pend_div_d;
            pend_valid_q <= pend_valid_d;
            cfg_ready_q  <= cfg_ready_d;
            div_out_q    <= div_out_d;
            tick_q       <= tick_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    taktteiler_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (core_clear),
        .enable_i    (running),
        .div_i       (div_active_q),
        .count_o     (count_cur),
        .count_next_o(count_next),
        .wrap_o      (core_wrap)
    );

    assign cfg_ready  = cfg_ready_q;
    assign busy       = busy_q;
    assign tick       = tick_q;
    assign div_out    = div_out_q;
    assign count      = count_cur;
    assign div_active = div_active_q;

endmodule

// File: tb/tb_taktteiler_ctrl.sv
// Testbench for taktteiler_ctrl: directed vector table, hand sequences and
// randomized stimulus against a period/queue-level reference model.
module tb_taktteiler_ctrl;

    localparam int W   = 10;
    localparam int DEF = 100;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, stop, cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready, busy, tick, div_out;
    logic [W-1:0] count, div_active;
    logic         oneshot = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: running flag, stop request, position in period,
    // divisor in force, number of completed periods, queue of accepted divisors.
    bit m_run, m_stopping;
    int m_phase, m_div, m_wraps;
    int pq[$];

    always #5 clk = ~clk;

    taktteiler_ctrl #(
        .WIDTH      (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .busy      (busy),
        .tick      (tick),
        .div_out   (div_out),
        .count     (count),
        .div_active(div_active)
`ifdef TAKT_ONESHOT_EN
        ,
        .oneshot   (oneshot)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_stopping = 0; m_phase = 0; m_div = DEF; m_wraps = 0;
        pq.delete();
    endfunction

    function automatic void model_step();
        int  d;
        bit  xfer;
        d    = (cfg_div == 0) ? 1 : int'(cfg_div);
        xfer = cfg_valid && (pq.size() == 0);
        if (!m_run) begin
            if (xfer) m_div = d;
            if (start && !stop) begin
                m_run      = 1;
                m_stopping = oneshot;
            end
            m_phase = 0;
            return;
        end
        if (m_phase != m_div - 1) begin
            m_phase++;
            if (xfer) pq.push_back(d);
            if (stop) m_stopping = 1;
        end else begin
            m_phase = 0;
            m_wraps++;
            if (pq.size() != 0) m_div = pq.pop_front();
            if (m_stopping) begin
                m_run      = 0;
                m_stopping = 0;
                if (xfer) m_div = d;
            end else begin
                if (xfer) pq.push_back(d);
                if (stop) m_stopping = 1;
            end
        end
    endfunction

    task automatic check_model();
        chk("model_count", 32'(count), 32'(m_phase));
        chk("model_tick", 32'(tick), 32'(m_run && (m_phase == m_div - 1)));
        chk("model_busy", 32'(busy), 32'(m_run));
        chk("model_div_out", 32'(div_out), 32'(m_wraps & 1));
        chk("model_cfg_ready", 32'(cfg_ready), 32'(pq.size() == 0));
        chk("model_div_active", 32'(div_active), 32'(m_div));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; cfg_valid = 0; cfg_div = '0; oneshot = 0;
    endtask

    typedef struct {
        bit st, sp, cv;
        int cd;
        int e_cnt;
        bit e_tick, e_busy, e_dout;
        int e_div;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int ticks, toggles, first_tick;
        logic prev_dout;

        vecs[0]  = '{0, 0, 1, 4, 0, 0, 0, 0, 4};
        vecs[1]  = '{1, 0, 0, 0, 0, 0, 1, 0, 4};
        vecs[2]  = '{0, 0, 0, 0, 1, 0, 1, 0, 4};
        vecs[3]  = '{0, 1, 0, 0, 2, 0, 1, 0, 4};
        vecs[4]  = '{0, 0, 0, 0, 3, 1, 1, 0, 4};
        vecs[5]  = '{1, 1, 0, 0, 0, 0, 0, 1, 4};
        vecs[6]  = '{1, 1, 0, 0, 0, 0, 0, 1, 4};
        vecs[7]  = '{0, 0, 1, 0, 0, 0, 0, 1, 1};
        vecs[8]  = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
        vecs[9]  = '{0, 0, 0, 0, 0, 1, 1, 0, 1};
        vecs[10] = '{0, 1, 0, 0, 0, 1, 1, 1, 1};
        vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_count", 32'(count), 0);
        chk("reset_tick", 32'(tick), 0);
        chk("reset_div_out", 32'(div_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cfg_ready", 32'(cfg_ready), 1);
        chk("reset_div_active", 32'(div_active), DEF);
        reset = 1'b0;
        model_reset();

        // Directed vector table: div 4 run/stop, start+stop in IDLE, divisor 0 -> 1.
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].st; stop = vecs[i].sp; cfg_valid = vecs[i].cv; cfg_div = W'(vecs[i].cd);
            cycle();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].e_tick));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("vec%0d_div_out", i), 32'(div_out), 32'(vecs[i].e_dout));
            chk($sformatf("vec%0d_div_active", i), 32'(div_active), 32'(vecs[i].e_div));
        end
        idle_inputs();

        // Divisor 5 in IDLE, then change to 3 mid-period.
        cfg_valid = 1; cfg_div = 5; cycle();
        chk("idle_cfg_div5", 32'(div_active), 5);
        cfg_valid = 0; start = 1; cycle(); start = 0;
        chk("run5_first_count", 32'(count), 0);
        cycle();
        chk("run5_count1", 32'(count), 1);
        cfg_valid = 1; cfg_div = 3; cycle(); cfg_valid = 0;
        chk("pend_count2", 32'(count), 2);
        chk("pend_ready_low", 32'(cfg_ready), 0);
        chk("pend_old_div", 32'(div_active), 5);
        cycle(); cycle();
        chk("pend_count4", 32'(count), 4);
        chk("pend_tick_at4", 32'(tick), 1);
        chk("pend_ready_still_low", 32'(cfg_ready), 0);
        cycle();
        chk("pend_applied", 32'(div_active), 3);
        chk("pend_ready_back", 32'(cfg_ready), 1);
        cycle(); cycle();
        chk("div3_tick_at2", 32'(tick), 1);

        // Transfer on the wrap cycle itself takes effect one period later.
        cfg_valid = 1; cfg_div = 7; cycle(); cfg_valid = 0;
        chk("wrapxfer_still3", 32'(div_active), 3);
        chk("wrapxfer_ready_low", 32'(cfg_ready), 0);
        cycle(); cycle(); cycle();
        chk("wrapxfer_applied", 32'(div_active), 7);

        // Asynchronous reset mid-period discards the pending divisor.
        cycle(); cycle();
        cfg_valid = 1; cfg_div = 9; cycle(); cfg_valid = 0;
        #2 reset = 1'b1;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_tick", 32'(tick), 0);
        chk("async_div_out", 32'(div_out), 0);
        chk("async_div_active", 32'(div_active), DEF);
        chk("async_busy", 32'(busy), 0);
        chk("async_ready", 32'(cfg_ready), 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(); cycle();
        chk("pending_discarded", 32'(div_active), DEF);

        // Default divisor: tick every 100 cycles, div_out period 200.
        start = 1; cycle(); start = 0;
        ticks = 0; toggles = 0; first_tick = -1; prev_dout = div_out;
        for (int i = 1; i <= 250; i++) begin
            cycle();
            if (tick) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
            if (div_out != prev_dout) toggles++;
            prev_dout = div_out;
        end
        chk("def_first_tick", 32'(first_tick), 99);
        chk("def_tick_count", 32'(ticks), 2);
        chk("def_toggle_count", 32'(toggles), 2);
        stop = 1; cycle(); stop = 0;
        for (int i = 0; i < 110; i++) cycle();
        chk("def_stopped", 32'(busy), 0);

`ifdef TAKT_ONESHOT_EN
        // One-shot: a single period of 6, one tick, then IDLE.
        cfg_valid = 1; cfg_div = 6; cycle(); cfg_valid = 0;
        start = 1; oneshot = 1; cycle(); start = 0; oneshot = 0;
        ticks = 0; first_tick = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (tick) begin
                ticks++;
                if (first_tick < 0) first_tick = i;
            end
        end
        chk("oneshot_ticks", 32'(ticks), 1);
        chk("oneshot_tick_pos", 32'(first_tick), 5);
        chk("oneshot_idle", 32'(busy), 0);
`endif

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 9) == 0);
            stop      = ($urandom_range(0, 24) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_div   = W'($urandom_range(0, 9));
`ifdef TAKT_ONESHOT_EN
            oneshot   = ($urandom_range(0, 3) == 0);
`endif
            cycle();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/taktteiler_ctrl.md
Name: taktteiler_ctrl

Overview:
- Controller and sequencer for the programmable clock divider (Taktteiler) datapath.
- Owns a WIDTH-bit period counter and exposes start, stop and config controls.
- Accepts new divide ratios over a valid/ready handshake and applies each one only at a period boundary, so no period is ever truncated.
- Outputs:
  - `tick`: one-cycle clock-enable pulse, one per period.
  - `div_out`: 50%-toggle divided clock level.
  - `count`: the live counter value.

Parameters:
- WIDTH, 10, width of counter, divisor and count output.
- DEFAULT_DIV, 100, divisor loaded at reset; must satisfy 1..2^WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  level/pulse; begin counting when IDLE.
- stop  in  1  request graceful stop at end of current period.
- cfg_valid  in  1  new divisor offered.
- cfg_div  in  WIDTH  offered divisor (period in clk cycles).
- cfg_ready  out  1  controller can accept a divisor this cycle.
- busy  out  1  high in RUN or STOPPING.
- tick  out  1  one-cycle pulse on the last cycle of each period.
- div_out  out  1  toggles at every period wrap.
- count  out  WIDTH  current counter value, 0..div_active-1.
- div_active  out  WIDTH  divisor currently in force.

Behaviour:
- Reset (async, immediate):
  - State = IDLE; count = 0; tick = 0; div_out = 0; busy = 0.
  - div_active = DEFAULT_DIV; pending flag = 0; cfg_ready = 1.
- States:
  - IDLE: count held at 0, tick = 0.
    - start = 1 → RUN next cycle, with count = 0 in the first RUN cycle.
  - RUN: count increments by 1 per cycle.
    - While count == div_active-1, tick = 1 (registered, aligned with that count value).
    - Next cycle: count = 0 and div_out toggles.
    - stop = 1 → STOPPING; count is not disturbed.
  - STOPPING: counts exactly as RUN.
    - At the wrap cycle (tick = 1): → IDLE, count = 0, div_out toggles as usual.
    - stop and start are ignored while in this state.
- Simultaneous start and stop in IDLE: stop wins; stays IDLE. start in RUN is ignored.
- Config handshake: transfer occurs when cfg_valid && cfg_ready.
  - cfg_div == 0 is coerced to 1.
  - Divisor 1 gives tick = 1 every cycle and count = 0 constant.
  - In IDLE: div_active = cfg_div on the next cycle; cfg_ready stays 1.
  - In RUN/STOPPING: the divisor is latched into the pending register and cfg_ready drops the next cycle.
  - At the next wrap: div_active = pending, pending cleared, cfg_ready = 1 the cycle after the wrap.
  - The period in which the transfer occurred completes at the old divisor.
- Transfer on the wrap cycle itself: takes effect at the following wrap, not the current one.
- Return to IDLE with a pending divisor: pending is applied at the IDLE entry.
- Arithmetic:
  - Compare is count == div_active-1 in WIDTH bits.
  - count never exceeds 2^WIDTH-2, so no overflow.
- Reset mid-period: all state returns to reset values immediately; the pending divisor is discarded.

Optional Feature:
- Macro TAKT_ONESHOT_EN.
- Defined:
  - Adds input port `oneshot` (1 bit), sampled with start in IDLE.
  - If oneshot = 1, the controller enters STOPPING directly.
  - Result: exactly one full period, one tick, one div_out toggle, then IDLE.
- Undefined:
  - Port absent.
  - Start always enters RUN; only stop ends counting.

Decomposition:
- Package `taktteiler_pkg`:
  - State encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOPPING = 2'd2.
  - Default WIDTH = 10 and MIN_DIV = 1.
- Sub-module `taktteiler_core`:
  - Contains the counter with load/clear/enable and the wrap compare.
  - Produces count and a wrap flag.
- `taktteiler_ctrl` keeps the FSM, the pending-config register, div_out and the handshake.

Test Plan:
- Reset, then start = 1 for 1 cycle with DEFAULT_DIV = 100 → tick every 100 cycles, count 0..99, div_out period 200 cycles, busy = 1.
- IDLE, cfg_div = 5 handshake, then start → div_active = 5 the next cycle; ticks every 5 cycles.
- RUN at div 5, cfg_div = 3 transfer while count = 1 → count continues to 4, wrap, then ticks every 3 cycles; cfg_ready low from transfer+1 until wrap+1.
- RUN at div 4, stop pulse at count = 1 → counts 2, 3 with tick at 3, then IDLE, count 0, busy 0; start and stop together in IDLE → stays IDLE.
- cfg_div = 0 → div_active = 1; tick constant 1 in RUN. Reset asserted mid-period → count = 0, tick = 0, div_out = 0, div_active = 100 asynchronously.
- TAKT_ONESHOT_EN defined, div 6, start + oneshot → exactly one tick at cycle 6, then IDLE.
